// File: rtl/mmio_pkg.sv
// Shared encodings for the MMIO master: access sizes, FSM states and the word-align mask.
package mmio_pkg;

   localparam logic [1:0]  SIZE_BYTE       = 2'b00;
   localparam logic [1:0]  SIZE_HALF       = 2'b01;
   localparam logic [1:0]  SIZE_WORD       = 2'b10;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_GAP,
      ST_RESP
   } state_t;

   // Size 2'b11 falls into the word case everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return byte_off[0];
         default:   return byte_off != 2'b00;
      endcase
   endfunction

   function automatic logic is_sub_word(input logic [1:0] size);
      return (size == SIZE_BYTE) || (size == SIZE_HALF);
   endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane steering between the 32-bit MMIO word and sub-word CPU accesses:
// load extraction with sign/zero extension, and read-modify-write store merging.
module mmio_lane_align
   import mmio_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  byte_off,
   input  logic [31:0] read_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      case (byte_off)
         2'd0:    lane_byte = read_word[7:0];
         2'd1:    lane_byte = read_word[15:8];
         2'd2:    lane_byte = read_word[23:16];
         default: lane_byte = read_word[31:24];
      endcase
      lane_half = byte_off[1] ? read_word[31:16] : read_word[15:0];
      case (size)
         SIZE_BYTE: load_data = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
         SIZE_HALF: load_data = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
         default:   load_data = read_word;
      endcase
   end

   // A word store bypasses the merge and writes the CPU data untouched.
   always_comb begin
      merged_word = read_word;
      case (size)
         SIZE_BYTE: begin
            case (byte_off)
               2'd0:    merged_word[7:0]   = store_data[7:0];
               2'd1:    merged_word[15:8]  = store_data[7:0];
               2'd2:    merged_word[23:16] = store_data[7:0];
               default: merged_word[31:24] = store_data[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (byte_off[1])
               merged_word[31:16] = store_data[15:0];
            else
               merged_word[15:0] = store_data[15:0];
         end
         default: merged_word = store_data;
      endcase
   end

endmodule

// File: rtl/mmio_master.sv
// CPU-side MMIO bus initiator: one load/store request in, one response out, with
// sub-word read-modify-write, misalignment rejection and a strobe timeout.
module mmio_master
   import mmio_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
)(
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic        cpu_req_we,
   input  logic [1:0]  cpu_req_size,
   input  logic        cpu_req_unsigned,
   input  logic [31:0] cpu_req_addr,
   input  logic [31:0] cpu_req_wdata,
   output logic        cpu_resp_valid,
   output logic [31:0] cpu_resp_rdata,
   output logic        cpu_resp_err,
   output logic        mmio_read,
   output logic        mmio_write,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_write_data,
   input  logic        mmio_done,
   input  logic [31:0] mmio_read_data
);

   state_t               state;
   state_t               next_state;
   logic                 req_we;
   logic [1:0]           req_size;
   logic                 req_unsigned;
   logic [31:0]          req_addr;
   logic [31:0]          req_wdata;
   logic [31:0]          read_word;
   logic                 err_flag;
   logic                 rmw_pending;
   logic [TIMEOUT_W-1:0] wait_count;
   logic                 strobe_active;
   logic                 timeout_hit;
   logic                 req_misaligned;
   logic [31:0]          load_data;
   logic [31:0]          merged_word;

   assign strobe_active  = (state == ST_READ) || (state == ST_WRITE);
   assign req_misaligned = is_misaligned(cpu_req_size, cpu_req_addr[1:0]);
   assign timeout_hit    = strobe_active && !mmio_done &&
                           (wait_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

   mmio_lane_align u_lane_align (
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .byte_off    (req_addr[1:0]),
      .read_word   (read_word),
      .store_data  (req_wdata),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge sys_clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // GAP always follows a strobe phase so the responder can release done.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (cpu_req_valid) begin
               if (req_misaligned)
                  next_state = ST_RESP;
               else if (cpu_req_we && !is_sub_word(cpu_req_size))
                  next_state = ST_WRITE;
               else
                  next_state = ST_READ;
            end
         end
         ST_READ, ST_WRITE: begin
            if (mmio_done || timeout_hit)
               next_state = ST_GAP;
         end
         ST_GAP:  next_state = rmw_pending ? ST_WRITE : ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Request capture, read-data capture and timeout bookkeeping; an abort
   // cancels any write still owed by a read-modify-write.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         req_we       <= 1'b0;
         req_size     <= SIZE_WORD;
         req_unsigned <= 1'b0;
         req_addr     <= '0;
         req_wdata    <= '0;
         read_word    <= '0;
         err_flag     <= 1'b0;
         rmw_pending  <= 1'b0;
         wait_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req_valid) begin
                  req_we       <= cpu_req_we;
                  req_size     <= cpu_req_size;
                  req_unsigned <= cpu_req_unsigned;
                  req_addr     <= cpu_req_addr;
                  req_wdata    <= cpu_req_wdata;
                  read_word    <= '0;
                  err_flag     <= req_misaligned;
                  rmw_pending  <= cpu_req_we && is_sub_word(cpu_req_size) && !req_misaligned;
                  wait_count   <= '0;
               end
            end
            ST_READ, ST_WRITE: begin
               if (mmio_done) begin
                  if (state == ST_READ)
                     read_word <= mmio_read_data;
               end else if (timeout_hit) begin
                  err_flag    <= 1'b1;
                  rmw_pending <= 1'b0;
               end else begin
                  wait_count <= wait_count + TIMEOUT_W'(1);
               end
            end
            ST_GAP: begin
               rmw_pending <= 1'b0;
               wait_count  <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cpu_req_ready   = (state == ST_IDLE);
      mmio_read       = (state == ST_READ);
      mmio_write      = (state == ST_WRITE);
      mmio_addr       = strobe_active ? (req_addr & WORD_ALIGN_MASK) : '0;
      mmio_write_data = (state == ST_WRITE) ? merged_word : '0;
      cpu_resp_valid  = (state == ST_RESP);
      cpu_resp_err    = (state == ST_RESP) && err_flag;
      cpu_resp_rdata  = ((state == ST_RESP) && !err_flag && !req_we) ? load_data : '0;
   end

endmodule

// File: tb/tb_mmio_master.sv
// Self-checking bench for mmio_master: a transaction-level model predicts each response,
// its latency and the MMIO strobes it causes; a per-cycle monitor compares the DUT against it.
module tb_mmio_master;

   localparam int TIMEOUT = 4;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic        cpu_req_we;
   logic [1:0]  cpu_req_size;
   logic        cpu_req_unsigned;
   logic [31:0] cpu_req_addr;
   logic [31:0] cpu_req_wdata;
   logic        cpu_resp_valid;
   logic [31:0] cpu_resp_rdata;
   logic        cpu_resp_err;
   logic        mmio_read;
   logic        mmio_write;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_write_data;
   logic        mmio_done;
   logic [31:0] mmio_read_data;

   logic [31:0] dev_word;
   logic        dev_stuck;

   int n_compared   = 0;
   int n_mismatched = 0;
   int resp_count   = 0;

   logic [31:0] exp_rdata, exp_wdata, exp_addr;
   logic        exp_err;
   int          exp_lat, exp_nr, exp_nw, exp_wcyc;

   logic        busy = 1'b0;
   int          cyc, nr, nw, first_wcyc;
   logic [31:0] seen_wdata;

   logic [31:0] last_rdata, last_wdata;
   logic        last_err;
   int          last_lat, last_nr, last_nw;

   mmio_master #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .TIMEOUT_W      (3)
   ) dut (
      .sys_clk          (sys_clk),
      .rst              (rst),
      .cpu_req_valid    (cpu_req_valid),
      .cpu_req_ready    (cpu_req_ready),
      .cpu_req_we       (cpu_req_we),
      .cpu_req_size     (cpu_req_size),
      .cpu_req_unsigned (cpu_req_unsigned),
      .cpu_req_addr     (cpu_req_addr),
      .cpu_req_wdata    (cpu_req_wdata),
      .cpu_resp_valid   (cpu_resp_valid),
      .cpu_resp_rdata   (cpu_resp_rdata),
      .cpu_resp_err     (cpu_resp_err),
      .mmio_read        (mmio_read),
      .mmio_write       (mmio_write),
      .mmio_addr        (mmio_addr),
      .mmio_write_data  (mmio_write_data),
      .mmio_done        (mmio_done),
      .mmio_read_data   (mmio_read_data)
   );

   always #5 sys_clk = ~sys_clk;

   assign mmio_done      = !dev_stuck && (mmio_read || mmio_write);
   assign mmio_read_data = (mmio_done && mmio_read) ? dev_word : 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] word, input logic stuck);
      int          nbytes;
      int          off;
      logic [31:0] mask;
      logic [31:0] v;
      nbytes    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      off       = int'(addr[1:0]);
      mask      = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 64'd1);
      exp_addr  = addr & 32'hFFFF_FFFC;
      exp_rdata = '0;
      exp_wdata = '0;
      exp_err   = 1'b0;
      exp_nr    = 0;
      exp_nw    = 0;
      exp_wcyc  = 0;
      if (off % nbytes != 0) begin
         exp_err = 1'b1;
         exp_lat = 1;
      end else if (stuck) begin
         exp_err = 1'b1;
         exp_lat = TIMEOUT + 2;
         if (we && nbytes == 4) exp_nw = TIMEOUT;
         else                   exp_nr = TIMEOUT;
      end else if (!we) begin
         v = (word >> (8 * off)) & mask;
         if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
         exp_rdata = v;
         exp_lat   = 3;
         exp_nr    = 1;
      end else if (nbytes == 4) begin
         exp_wdata = wdata;
         exp_lat   = 3;
         exp_nw    = 1;
         exp_wcyc  = 1;
      end else begin
         exp_wdata = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
         exp_lat   = 5;
         exp_nr    = 1;
         exp_nw    = 1;
         exp_wcyc  = 3;
      end
   endtask

   // Monitor: every cycle out of reset, compare the DUT against the current prediction.
   always @(negedge sys_clk) begin
      if (rst) begin
         busy = 1'b0;
      end else begin
         checkOutput("ready", {31'b0, cpu_req_ready}, {31'b0, !busy});
         if (!mmio_write) checkOutput("wdata_idle", mmio_write_data, 32'h0);
         if (!cpu_resp_valid) checkOutput("rdata_idle", cpu_resp_rdata, 32'h0);
         if (busy) begin
            cyc++;
            checkOutput("one_strobe", {31'b0, mmio_read & mmio_write}, 32'h0);
            if (mmio_read || mmio_write) checkOutput("mmio_addr", mmio_addr, exp_addr);
            if (mmio_read) nr++;
            if (mmio_write) begin
               nw++;
               if (first_wcyc < 0) first_wcyc = cyc;
               seen_wdata = mmio_write_data;
            end
            if (cpu_resp_valid) begin
               checkOutput("resp_cycle", cyc, exp_lat);
               checkOutput("resp_rdata", cpu_resp_rdata, exp_rdata);
               checkOutput("resp_err", {31'b0, cpu_resp_err}, {31'b0, exp_err});
               checkOutput("read_cycles", nr, exp_nr);
               checkOutput("write_cycles", nw, exp_nw);
               if (exp_nw > 0 && !exp_err) begin
                  checkOutput("write_data", seen_wdata, exp_wdata);
                  checkOutput("write_cycle", first_wcyc, exp_wcyc);
               end
               last_rdata = cpu_resp_rdata;
               last_err   = cpu_resp_err;
               last_lat   = cyc;
               last_nr    = nr;
               last_nw    = nw;
               last_wdata = seen_wdata;
               resp_count++;
               busy = 1'b0;
            end else if (cyc > exp_lat) begin
               checkOutput("resp_missing", cyc, exp_lat);
               busy = 1'b0;
            end
         end else begin
            checkOutput("idle_resp", {31'b0, cpu_resp_valid}, 32'h0);
            checkOutput("idle_strobe", {30'b0, mmio_read, mmio_write}, 32'h0);
         end
         if (!busy && cpu_req_valid && cpu_req_ready) begin
            predict(cpu_req_we, cpu_req_size, cpu_req_unsigned, cpu_req_addr,
                    cpu_req_wdata, dev_word, dev_stuck);
            busy       = 1'b1;
            cyc        = 0;
            nr         = 0;
            nw         = 0;
            first_wcyc = -1;
            seen_wdata = '0;
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] word, input logic stuck,
                                input logic wait_resp);
      logic acc;
      int   start;
      int   n;
      @(posedge sys_clk);
      #2;
      dev_word         = word;
      dev_stuck        = stuck;
      cpu_req_we       = we;
      cpu_req_size     = size;
      cpu_req_unsigned = uns;
      cpu_req_addr     = addr;
      cpu_req_wdata    = wdata;
      cpu_req_valid    = 1'b1;
      start            = resp_count;
      acc              = 1'b0;
      n                = 0;
      while (!acc && n < 20) begin
         @(negedge sys_clk);
         acc = cpu_req_ready;
         @(posedge sys_clk);
         #2;
         n++;
      end
      cpu_req_valid = 1'b0;
      if (!acc) checkOutput("accept_timeout", 32'h0, 32'h1);
      if (wait_resp) begin
         n = 0;
         while (resp_count == start && n < 40) begin
            @(negedge sys_clk);
            #1;
            n++;
         end
         checkOutput("resp_seen", resp_count, start + 1);
      end
   endtask

   initial begin
      rst              = 1'b1;
      cpu_req_valid    = 1'b0;
      cpu_req_we       = 1'b0;
      cpu_req_size     = 2'b10;
      cpu_req_unsigned = 1'b0;
      cpu_req_addr     = '0;
      cpu_req_wdata    = '0;
      dev_word         = '0;
      dev_stuck        = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("rst_ready", {31'b0, cpu_req_ready}, 32'h1);
      checkOutput("rst_resp_valid", {31'b0, cpu_resp_valid}, 32'h0);
      checkOutput("rst_resp_err", {31'b0, cpu_resp_err}, 32'h0);
      checkOutput("rst_resp_rdata", cpu_resp_rdata, 32'h0);
      checkOutput("rst_strobes", {30'b0, mmio_read, mmio_write}, 32'h0);
      checkOutput("rst_mmio_addr", mmio_addr, 32'h0);
      checkOutput("rst_mmio_wdata", mmio_write_data, 32'h0);
      @(posedge sys_clk);
      #2;
      rst = 1'b0;

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      checkOutput("lw_rdata", last_rdata, 32'hDEAD_BEEF);
      checkOutput("lw_latency", last_lat, 3);
      checkOutput("lw_read_cycles", last_nr, 1);

      applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_1234, 1'b0, 1'b1);
      checkOutput("lb_rdata", last_rdata, 32'hFFFF_FF80);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h1000_0002, 32'h0, 32'h80FF_1234, 1'b0, 1'b1);
      checkOutput("lhu_rdata", last_rdata, 32'h0000_80FF);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h1000_0000, 32'h0, 32'h1234_8001, 1'b0, 1'b1);
      checkOutput("lh_rdata", last_rdata, 32'hFFFF_8001);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h1000_0001, 32'h0, 32'h0000_9A00, 1'b0, 1'b1);
      checkOutput("lbu_rdata", last_rdata, 32'h0000_009A);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h2000_0004, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000_0001, 32'h0000_00AB, 32'h1122_3344, 1'b0, 1'b1);
      checkOutput("sb_wdata", last_wdata, 32'h1122_AB44);
      checkOutput("sb_latency", last_lat, 5);
      checkOutput("sb_rdata", last_rdata, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h5555_BEEF, 32'h1122_3344, 1'b0, 1'b1);
      checkOutput("sh_wdata", last_wdata, 32'hBEEF_3344);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'hCAFE_F00D, 32'h1122_3344, 1'b0, 1'b1);
      checkOutput("sw_wdata", last_wdata, 32'hCAFE_F00D);
      checkOutput("sw_latency", last_lat, 3);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000_0002, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
      checkOutput("sw_misaligned_err", {31'b0, last_err}, 32'h1);
      checkOutput("sw_misaligned_latency", last_lat, 1);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h1000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      checkOutput("lh_misaligned_rdata", last_rdata, 32'h0);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_0020, 32'h0, 32'h7777_7777, 1'b1, 1'b1);
      checkOutput("timeout_read_cycles", last_nr, 4);
      checkOutput("timeout_err", {31'b0, last_err}, 32'h1);
      checkOutput("timeout_rdata", last_rdata, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h1000_0022, 32'h0000_1111, 32'h7777_7777, 1'b1, 1'b1);
      checkOutput("timeout_sh_writes", last_nw, 0);
      checkOutput("timeout_sh_err", {31'b0, last_err}, 32'h1);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000_0030, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0);
      @(negedge sys_clk);
      checkOutput("rst_pre_write", {31'b0, mmio_write}, 32'h1);
      begin
         int saved;
         saved = resp_count;
         @(posedge sys_clk);
         #2;
         rst = 1'b1;
         @(posedge sys_clk);
         #2;
         rst = 1'b0;
         @(negedge sys_clk);
         checkOutput("rst_mid_write", {31'b0, mmio_write}, 32'h0);
         checkOutput("rst_mid_ready", {31'b0, cpu_req_ready}, 32'h1);
         repeat (8) @(negedge sys_clk);
         checkOutput("rst_no_resp", resp_count, saved);
      end

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_0040, 32'h0, 32'h0123_4567, 1'b0, 1'b1);
      checkOutput("post_rst_lw", last_rdata, 32'h0123_4567);

      repeat (2) @(posedge sys_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, compared=%0d", n_compared);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
